// File: rtl/user_clk_sel_pkg.sv
// Shared types and helpers for the clock-source selection sequencer.
package user_clk_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SETTLE
  } state_e;

  localparam int DEF_PRE_CYCLES    = 16;
  localparam int DEF_SETTLE_CYCLES = 64;

  // Bits needed to index 'value' items; never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/user_hold_counter.sv
// Loadable down-counter; tc flags the final cycle of a hold interval.
module user_hold_counter #(
  parameter int CNT_W     = 7,
  parameter int RESET_VAL = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(RESET_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tc = (cnt <= CNT_W'(1));

endmodule

// File: rtl/user_clk_sel_ctrl.sv
// Sequenced N-way clock-source select: reset downstream, switch, settle, release.
// Optional lock supervision is built when USER_CLK_SEL_CTRL_LOCK_GUARD_EN is defined.
module user_clk_sel_ctrl
  import user_clk_sel_pkg::*;
#(
  parameter int   NUM_CLKS      = 4,
  parameter int   DEFAULT_SEL   = 0,
  parameter int   PRE_CYCLES    = DEF_PRE_CYCLES,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int  SEL_W         = clog2_min1(NUM_CLKS)
) (
  input  logic             aclk,
  input  logic             aresetn,
`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
  input  logic [NUM_CLKS-1:0] src_locked,
`endif
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_sel,
  output logic             req_ready,
  output logic [SEL_W-1:0] clk_sel,
  output logic             dst_rst_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int             MAX_HOLD  = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
  localparam int             CNT_W     = clog2_min1(MAX_HOLD + 1);
  localparam logic [SEL_W-1:0] DEF_SEL = SEL_W'(DEFAULT_SEL);
  localparam logic [SEL_W:0]   NUM_LIM = (SEL_W + 1)'(NUM_CLKS);

  state_e           state;
  logic [SEL_W-1:0] target;
  logic             cnt_tc;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             accept;
  logic             req_ok;
  logic             lock_drop;
  logic             start_switch;
  logic             same_req;
  logic             reject;
  logic [SEL_W-1:0] next_target;

`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
  logic [NUM_CLKS-1:0] lock_meta;
  logic [NUM_CLKS-1:0] lock_sync;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      lock_meta <= '0;
      lock_sync <= '0;
    end else begin
      lock_meta <= src_locked;
      lock_sync <= lock_meta;
    end
  end
`endif

  // NOTE: every signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    accept    = req_valid && req_ready;
    req_ok    = ({1'b0, req_sel} < NUM_LIM);
    lock_drop = 1'b0;
`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
    req_ok    = req_ok && lock_sync[req_sel];
    // A pending request wins over lock loss; the lost source is revisited next cycle.
    lock_drop = (state == ST_IDLE) && !accept && !lock_sync[clk_sel] && (clk_sel != DEF_SEL);
`endif
    same_req     = accept && req_ok && (req_sel == clk_sel);
    reject       = accept && !req_ok;
    start_switch = (accept && req_ok && (req_sel != clk_sel)) || lock_drop;
    next_target  = lock_drop ? DEF_SEL : req_sel;
    cnt_load     = start_switch || ((state == ST_DRAIN) && cnt_tc);
    cnt_load_val = (state == ST_IDLE) ? CNT_W'(PRE_CYCLES) : CNT_W'(SETTLE_CYCLES);
  end

  user_hold_counter #(
    .CNT_W     (CNT_W),
    .RESET_VAL (SETTLE_CYCLES)
  ) u_hold (
    .clk      (aclk),
    .rst_n    (aresetn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (state != ST_IDLE),
    .tc       (cnt_tc)
  );

  // NOTE: clk_sel is reset asynchronously too; that is safe only because dst_rst_n drops with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_SETTLE;
      target    <= DEF_SEL;
      clk_sel   <= DEF_SEL;
      dst_rst_n <= 1'b0;
      req_ready <= 1'b0;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_switch) begin
            state     <= ST_DRAIN;
            target    <= next_target;
            dst_rst_n <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
          end else if (same_req) begin
            done <= 1'b1;
          end else if (reject) begin
            err <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (cnt_tc) begin
            state   <= ST_SETTLE;
            clk_sel <= target;
          end
        end
        ST_SETTLE: begin
          if (cnt_tc) begin
            state     <= ST_IDLE;
            dst_rst_n <= 1'b1;
            done      <= 1'b1;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_SETTLE;
          dst_rst_n <= 1'b0;
          busy      <= 1'b1;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_user_clk_sel_ctrl.sv
// Directed bench for user_clk_sel_ctrl: a 4-source default instance and a 3-source instance.
module tb_user_clk_sel_ctrl;

  logic       aclk;
  logic       aresetn;

  logic       req_valid, req_ready, dst_rst_n, busy, done, err;
  logic [1:0] req_sel, clk_sel;

  logic       req_valid_3, req_ready_3, dst_rst_n_3, busy_3, done_3, err_3;
  logic [1:0] req_sel_3, clk_sel_3;

`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
  logic [3:0] src_locked;
  logic [2:0] src_locked_3;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int violations = 0;

  user_clk_sel_ctrl u_dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
    .src_locked(src_locked),
`endif
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .req_ready (req_ready),
    .clk_sel   (clk_sel),
    .dst_rst_n (dst_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  user_clk_sel_ctrl #(
    .NUM_CLKS      (3),
    .DEFAULT_SEL   (0),
    .PRE_CYCLES    (2),
    .SETTLE_CYCLES (3)
  ) u_dut3 (
    .aclk      (aclk),
    .aresetn   (aresetn),
`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
    .src_locked(src_locked_3),
`endif
    .req_valid (req_valid_3),
    .req_sel   (req_sel_3),
    .req_ready (req_ready_3),
    .clk_sel   (clk_sel_3),
    .dst_rst_n (dst_rst_n_3),
    .busy      (busy_3),
    .done      (done_3),
    .err       (err_3)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Invariants: clk_sel never moves while downstream is out of reset; done/err exclusive.
  logic [1:0] prev_sel = 2'd0;
  logic       prev_dst = 1'b0;
  always @(negedge aclk) begin
    if (aresetn) begin
      if (clk_sel !== prev_sel && prev_dst) violations++;
      if (done && err) violations++;
      if (done_3 && err_3) violations++;
      prev_sel = clk_sel;
      prev_dst = dst_rst_n;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    aresetn     = 1'b0;
    req_valid   = 1'b0;
    req_sel     = 2'd0;
    req_valid_3 = 1'b0;
    req_sel_3   = 2'd0;
`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
    src_locked   = 4'hF;
    src_locked_3 = 3'h7;
`endif
    tick(3);
    check("rst_clk_sel",   32'(clk_sel),   32'd0);
    check("rst_dst_rst_n", 32'(dst_rst_n), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);

    // Init settle: release on the 64th edge after deassertion.
    aresetn = 1'b1;
    tick(63);
    check("init63_dst",   32'(dst_rst_n), 32'd0);
    check("init63_done",  32'(done),      32'd0);
    check("init63_ready", 32'(req_ready), 32'd0);
    tick(1);
    check("init64_dst",   32'(dst_rst_n), 32'd1);
    check("init64_done",  32'(done),      32'd1);
    check("init64_ready", 32'(req_ready), 32'd1);
    check("init64_busy",  32'(busy),      32'd0);
    check("init64_sel",   32'(clk_sel),   32'd0);

    // Switch to source 2: DRAIN at T+1, new select at T+17, release at T+81.
    req_valid = 1'b1;
    req_sel   = 2'd2;
    tick(1);
    check("sw2_t1_dst",   32'(dst_rst_n), 32'd0);
    check("sw2_t1_busy",  32'(busy),      32'd1);
    check("sw2_t1_ready", 32'(req_ready), 32'd0);
    check("sw2_t1_sel",   32'(clk_sel),   32'd0);
    req_valid = 1'b0;
    tick(15);
    check("sw2_t16_sel",  32'(clk_sel),   32'd0);
    tick(1);
    check("sw2_t17_sel",  32'(clk_sel),   32'd2);
    check("sw2_t17_dst",  32'(dst_rst_n), 32'd0);
    tick(63);
    check("sw2_t80_dst",  32'(dst_rst_n), 32'd0);
    check("sw2_t80_done", 32'(done),      32'd0);
    tick(1);
    check("sw2_t81_dst",   32'(dst_rst_n), 32'd1);
    check("sw2_t81_done",  32'(done),      32'd1);
    check("sw2_t81_ready", 32'(req_ready), 32'd1);
    check("sw2_t81_busy",  32'(busy),      32'd0);

    // Same-source request: done next cycle, no reset, no busy.
    req_valid = 1'b1;
    req_sel   = 2'd2;
    tick(1);
    check("same_done", 32'(done),      32'd1);
    check("same_busy", 32'(busy),      32'd0);
    check("same_dst",  32'(dst_rst_n), 32'd1);
    check("same_sel",  32'(clk_sel),   32'd2);
    req_valid = 1'b0;
    tick(1);
    check("same_done_clr", 32'(done), 32'd0);
    check("same_busy2",    32'(busy), 32'd0);

    // Switch to 3 while a different request stays held; it must not be taken mid-sequence.
    req_valid = 1'b1;
    req_sel   = 2'd3;
    tick(1);
    check("sw3_busy", 32'(busy),      32'd1);
    check("sw3_dst",  32'(dst_rst_n), 32'd0);
    req_sel = 2'd1;
    tick(16);
    check("sw3_sel",   32'(clk_sel),   32'd3);
    check("sw3_ready", 32'(req_ready), 32'd0);
    tick(20);
    check("sw3_mid_sel",  32'(clk_sel), 32'd3);
    check("sw3_mid_busy", 32'(busy),    32'd1);

    // Reset in the middle of SETTLE: immediate return to reset values.
    aresetn = 1'b0;
    #1;
    check("arst_sel",   32'(clk_sel),   32'd0);
    check("arst_dst",   32'(dst_rst_n), 32'd0);
    check("arst_busy",  32'(busy),      32'd1);
    check("arst_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(63);
    check("reinit63_dst", 32'(dst_rst_n), 32'd0);
    tick(1);
    check("reinit_done", 32'(done),      32'd1);
    check("reinit_dst",  32'(dst_rst_n), 32'd1);
    check("reinit_sel",  32'(clk_sel),   32'd0);
    tick(1);

    // Three-source instance: index 3 is out of range.
    req_valid_3 = 1'b1;
    req_sel_3   = 2'd3;
    tick(1);
    check("oor_err",   32'(err_3),       32'd1);
    check("oor_done",  32'(done_3),      32'd0);
    check("oor_sel",   32'(clk_sel_3),   32'd0);
    check("oor_dst",   32'(dst_rst_n_3), 32'd1);
    check("oor_ready", 32'(req_ready_3), 32'd1);
    req_sel_3 = 2'd2;
    tick(1);
    check("n3_err_clr", 32'(err_3),       32'd0);
    check("n3_t1_dst",  32'(dst_rst_n_3), 32'd0);
    check("n3_t1_busy", 32'(busy_3),      32'd1);
    req_valid_3 = 1'b0;
    tick(1);
    check("n3_t2_sel",  32'(clk_sel_3),   32'd0);
    tick(1);
    check("n3_t3_sel",  32'(clk_sel_3),   32'd2);
    tick(2);
    check("n3_t5_done", 32'(done_3),      32'd0);
    check("n3_t5_dst",  32'(dst_rst_n_3), 32'd0);
    tick(1);
    check("n3_t6_done", 32'(done_3),      32'd1);
    check("n3_t6_dst",  32'(dst_rst_n_3), 32'd1);

`ifdef USER_CLK_SEL_CTRL_LOCK_GUARD_EN
    // Move to source 1, then drop its lock: automatic return to source 0.
    req_valid = 1'b1;
    req_sel   = 2'd1;
    tick(1);
    req_valid = 1'b0;
    tick(80);
    check("lk_sw1_done", 32'(done),    32'd1);
    check("lk_sw1_sel",  32'(clk_sel), 32'd1);
    src_locked[1] = 1'b0;
    tick(2);
    check("lk_t2_busy", 32'(busy),      32'd0);
    check("lk_t2_dst",  32'(dst_rst_n), 32'd1);
    tick(1);
    check("lk_t3_busy", 32'(busy),      32'd1);
    check("lk_t3_dst",  32'(dst_rst_n), 32'd0);
    tick(16);
    check("lk_sel0", 32'(clk_sel), 32'd0);
    tick(64);
    check("lk_done", 32'(done),      32'd1);
    check("lk_dst",  32'(dst_rst_n), 32'd1);
    req_valid = 1'b1;
    req_sel   = 2'd1;
    tick(1);
    check("lk_rej_err",  32'(err),       32'd1);
    check("lk_rej_busy", 32'(busy),      32'd0);
    check("lk_rej_sel",  32'(clk_sel),   32'd0);
    req_valid = 1'b0;
    tick(1);
`endif

    check("invariants", 32'(violations), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
